// File: rtl/approx_error_monitor.sv
// Error-statistics stage for the 8x8 approximate multiplier: three-stage pipeline
// (capture, error distance, accumulate) controlled by an IDLE/RUN/DRAIN/DONE FSM.
module approx_error_monitor #(
  parameter int N_SAMPLES = 256,
  parameter int ACC_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [15:0]      r,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] ed_sum,
  output logic [15:0]      ed_max,
  output logic [15:0]      err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] N_LIM = 16'(N_SAMPLES);

  state_t             state_r, state_s;
  logic [15:0]        cnt_r;
  logic               accept_s, clear_s;
  logic [7:0]         a1_r, b1_r;
  logic [15:0]        r1_r;
  logic               v1_r;
  logic [15:0]        exact_s;
  logic [16:0]        diff_s, neg_s;
  logic [15:0]        ed_s;
  logic [15:0]        ed2_r;
  logic               nz2_r, v2_r;
  logic [ACC_W:0]     sum_ext_s;
  logic [ACC_W-1:0]   sum_r, sum_s;
  logic [15:0]        max_r, max_s, errc_r, errc_s;

  assign accept_s = in_valid && in_ready;
  assign clear_s  = (state_r == IDLE) && start;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start) state_s = RUN; else state_s = IDLE;
      RUN:     if (cnt_r == N_LIM) state_s = DRAIN; else state_s = RUN;
      DRAIN:   if (!v1_r && !v2_r) state_s = DONE; else state_s = DRAIN;
      DONE:    if (res_ready) state_s = IDLE; else state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode from the state register and accept counter
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    res_valid = 1'b0;
    case (state_r)
      IDLE:    begin end
      RUN:     begin busy = 1'b1; in_ready = (cnt_r < N_LIM); end
      DRAIN:   busy = 1'b1;
      DONE:    res_valid = 1'b1;
      default: begin end
    endcase
  end

  // Accepted-sample counter, cleared at run start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt_r <= 16'd0;
    else if (clear_s)  cnt_r <= 16'd0;
    else if (accept_s) cnt_r <= cnt_r + 16'd1;
    else               cnt_r <= cnt_r;
  end

  // S1: capture accepted operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_r <= 8'd0; b1_r <= 8'd0; r1_r <= 16'd0; v1_r <= 1'b0;
    end else if (clear_s) begin
      v1_r <= 1'b0;
    end else begin
      v1_r <= accept_s;
      if (accept_s) begin
        a1_r <= a; b1_r <= b; r1_r <= r;
      end
    end
  end

  // S2 datapath: the 17-bit signed difference keeps both error signs; |diff| fits 16 bits
  always_comb begin
    exact_s = {8'd0, a1_r} * {8'd0, b1_r};
    diff_s  = {1'b0, exact_s} - {1'b0, r1_r};
    neg_s   = 17'd0 - diff_s;
    if (diff_s[16]) ed_s = neg_s[15:0];
    else            ed_s = diff_s[15:0];
  end

  // S2 register: error distance and nonzero flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ed2_r <= 16'd0; nz2_r <= 1'b0; v2_r <= 1'b0;
    end else if (clear_s) begin
      v2_r <= 1'b0;
    end else begin
      v2_r  <= v1_r;
      ed2_r <= ed_s;
      nz2_r <= (ed_s != 16'd0);
    end
  end

  // S3 next values with saturation
  always_comb begin
    sum_ext_s = {1'b0, sum_r} + {{(ACC_W-15){1'b0}}, ed2_r};
    if (sum_ext_s[ACC_W]) sum_s = {ACC_W{1'b1}};
    else                  sum_s = sum_ext_s[ACC_W-1:0];
    if (ed2_r > max_r) max_s = ed2_r;
    else               max_s = max_r;
    if (nz2_r && (errc_r != 16'hFFFF)) errc_s = errc_r + 16'd1;
    else                               errc_s = errc_r;
  end

  // S3 accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r <= {ACC_W{1'b0}}; max_r <= 16'd0; errc_r <= 16'd0;
    end else if (clear_s) begin
      sum_r <= {ACC_W{1'b0}}; max_r <= 16'd0; errc_r <= 16'd0;
    end else if (v2_r) begin
      sum_r <= sum_s; max_r <= max_s; errc_r <= errc_s;
    end
  end

  assign ed_sum  = sum_r;
  assign ed_max  = max_r;
  assign err_cnt = errc_r;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Directed table-driven bench: three monitor instances share the sample bus,
// each with its own start, to cover different N_SAMPLES / ACC_W settings.
module tb_approx_error_monitor;

  logic        clk, rst_n, in_valid, res_ready;
  logic [7:0]  a, b;
  logic [15:0] r;
  logic [2:0]  start_v, ir, bz, rv;
  logic [2:0][31:0] es;
  logic [2:0][15:0] em, ec;
  logic [31:0] es0, es2;
  logic [15:0] es1;
  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct packed { logic [7:0] a; logic [7:0] b; logic [15:0] r; } vec_t;
  typedef struct { int d; int first; int span; int n; logic [31:0] sum; logic [15:0] mx; logic [15:0] cnt; } run_t;

  vec_t vecs [16];
  run_t runs [4];

  assign es[0] = es0;
  assign es[1] = {16'd0, es1};
  assign es[2] = es2;

  approx_error_monitor #(.N_SAMPLES(4), .ACC_W(32)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in_valid(in_valid), .in_ready(ir[0]),
    .a(a), .b(b), .r(r), .busy(bz[0]), .res_valid(rv[0]), .res_ready(res_ready),
    .ed_sum(es0), .ed_max(em[0]), .err_cnt(ec[0]));
  approx_error_monitor #(.N_SAMPLES(3), .ACC_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in_valid(in_valid), .in_ready(ir[1]),
    .a(a), .b(b), .r(r), .busy(bz[1]), .res_valid(rv[1]), .res_ready(res_ready),
    .ed_sum(es1), .ed_max(em[1]), .err_cnt(ec[1]));
  approx_error_monitor #(.N_SAMPLES(16), .ACC_W(32)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .in_valid(in_valid), .in_ready(ir[2]),
    .a(a), .b(b), .r(r), .busy(bz[2]), .res_valid(rv[2]), .res_ready(res_ready),
    .ed_sum(es2), .ed_max(em[2]), .err_cnt(ec[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else pass_cnt++;
  endtask

  // Drive samples; vpat gives the in_valid pattern per cycle, bubbles carry junk operands
  task automatic feed(input int d, input int first, input int span, input int n, input logic [3:0] vpat);
    int k = 0;
    int c = 0;
    while (k < n && c < 400) begin
      if (vpat[c % 4]) begin
        in_valid = 1'b1;
        a = vecs[first + (k % span)].a;
        b = vecs[first + (k % span)].b;
        r = vecs[first + (k % span)].r;
      end else begin
        in_valid = 1'b0; a = 8'hFF; b = 8'hFF; r = 16'h0000;
      end
      if (vpat[c % 4] && ir[d]) k++;
      tick();
      c++;
    end
    in_valid = 1'b0;
    chk("feed_accepts", k, n);
  endtask

  task automatic wait_res(input int d, input int bound);
    int c = 0;
    while (!rv[d] && c < bound) begin
      tick();
      c++;
    end
    chk("res_valid_timeout", rv[d], 1'b1);
  endtask

  task automatic chk_bundle(input int d, input logic [31:0] s, input logic [15:0] m, input logic [15:0] n);
    chk("ed_sum", es[d], s);
    chk("ed_max", em[d], m);
    chk("err_cnt", ec[d], n);
  endtask

  // Back-to-back run with exact latency checks around the last accept
  task automatic run_strict(input int ri);
    int d;
    d = runs[ri].d;
    start_v[d] = 1'b1;
    tick();
    start_v[d] = 1'b0;
    chk("busy_after_start", bz[d], 1'b1);
    chk("in_ready_after_start", ir[d], 1'b1);
    feed(d, runs[ri].first, runs[ri].span, runs[ri].n, 4'b1111);
    chk("in_ready_full", ir[d], 1'b0);
    chk("res_valid_t0", rv[d], 1'b0);
    tick();
    chk("busy_drain", bz[d], 1'b1);
    chk("res_valid_t1", rv[d], 1'b0);
    tick();
    chk("res_valid_t2", rv[d], 1'b0);
    tick();
    chk("res_valid_t3", rv[d], 1'b1);
    chk("busy_done", bz[d], 1'b0);
    chk_bundle(d, runs[ri].sum, runs[ri].mx, runs[ri].cnt);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("res_valid_after_hs", rv[d], 1'b0);
  endtask

  initial begin
    vecs[0]  = '{8'd15,  8'd15,  16'd225};
    vecs[1]  = '{8'd0,   8'd200, 16'd0};
    vecs[2]  = '{8'd255, 8'd1,   16'd255};
    vecs[3]  = '{8'd16,  8'd16,  16'd256};
    vecs[4]  = '{8'd255, 8'd255, 16'd65000};
    vecs[5]  = '{8'd2,   8'd3,   16'd10};
    vecs[6]  = '{8'd7,   8'd7,   16'd49};
    vecs[7]  = '{8'd100, 8'd100, 16'd9990};
    vecs[8]  = '{8'd0,   8'd0,   16'd65535};
    vecs[9]  = '{8'd255, 8'd255, 16'd65025};
    vecs[10] = '{8'd1,   8'd1,   16'd0};
    vecs[11] = '{8'd200, 8'd100, 16'd19990};
    vecs[12] = '{8'd255, 8'd255, 16'd0};
    vecs[13] = '{8'd0,   8'd0,   16'd0};
    vecs[14] = '{8'd0,   8'd0,   16'd0};
    vecs[15] = '{8'd2,   8'd3,   16'd10};
    runs[0] = '{0, 0,  4, 4, 32'd0,     16'd0,     16'd0};
    runs[1] = '{0, 4,  4, 4, 32'd39,    16'd25,    16'd3};
    runs[2] = '{0, 8,  4, 4, 32'd65546, 16'd65535, 16'd3};
    runs[3] = '{1, 12, 1, 3, 32'd65535, 16'd65025, 16'd3};

    rst_n = 1'b0; start_v = 3'b000; in_valid = 1'b0; res_ready = 1'b0;
    a = 8'd0; b = 8'd0; r = 16'd0;
    tick();
    tick();
    chk("rst_in_ready", ir[0], 1'b0);
    chk("rst_busy", bz[0], 1'b0);
    chk("rst_res_valid", rv[0], 1'b0);
    chk_bundle(0, 32'd0, 16'd0, 16'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", ir[0], 1'b0);

    for (int i = 0; i < 4; i++) run_strict(i);

    // Bubbles plus backpressure on the result bundle
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    feed(0, 4, 4, 4, 4'b1001);
    wait_res(0, 20);
    for (int i = 0; i < 5; i++) begin
      chk("bp_res_valid", rv[0], 1'b1);
      chk("bp_ed_sum", es[0], 32'd39);
      tick();
    end
    chk_bundle(0, 32'd39, 16'd25, 16'd3);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("bp_after_hs_rv", rv[0], 1'b0);
    chk("bp_after_hs_busy", bz[0], 1'b0);
    chk("bp_after_hs_ir", ir[0], 1'b0);

    // start pulses in RUN and DRAIN, in_valid in DRAIN and DONE
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    feed(0, 4, 4, 2, 4'b1111);
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    chk("run_start_busy", bz[0], 1'b1);
    feed(0, 6, 2, 2, 4'b1111);
    tick();
    chk("drain_busy", bz[0], 1'b1);
    start_v[0] = 1'b1; in_valid = 1'b1; a = 8'd255; b = 8'd255; r = 16'd0;
    chk("drain_in_ready", ir[0], 1'b0);
    tick();
    start_v[0] = 1'b0;
    wait_res(0, 10);
    chk("done_in_ready", ir[0], 1'b0);
    tick();
    tick();
    chk_bundle(0, 32'd39, 16'd25, 16'd3);
    in_valid = 1'b0;
    start_v[0] = 1'b1; res_ready = 1'b1;
    tick();
    start_v[0] = 1'b0; res_ready = 1'b0;
    chk("hs_start_busy", bz[0], 1'b0);
    chk("hs_start_rv", rv[0], 1'b0);
    tick();
    chk("hs_start_stays_idle", bz[0], 1'b0);
    chk("hs_start_ir", ir[0], 1'b0);

    // Asynchronous reset in the middle of a run
    start_v[2] = 1'b1;
    tick();
    start_v[2] = 1'b0;
    feed(2, 15, 1, 10, 4'b1111);
    tick();
    tick();
    chk("mid_ed_sum", es[2], 32'd40);
    chk("mid_err_cnt", ec[2], 16'd10);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", bz[2], 1'b0);
    chk("arst_in_ready", ir[2], 1'b0);
    chk("arst_res_valid", rv[2], 1'b0);
    chk_bundle(2, 32'd0, 16'd0, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", bz[2], 1'b0);
    chk("post_rst_ir", ir[2], 1'b0);
    start_v[2] = 1'b1;
    tick();
    start_v[2] = 1'b0;
    feed(2, 15, 1, 16, 4'b1111);
    wait_res(2, 10);
    chk_bundle(2, 32'd64, 16'd4, 16'd16);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("clean_run_hs", rv[2], 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
